uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  UART transmit stage directly downstream of baud_rate_generator: consumes its Tx_sample_ENABLE tick
//  and serialises one byte per frame onto Tx_D.
//  Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
//  Byte-wide write interface toward the host; Tx_BUSY/Tx_DONE give flow control.
// PARAMETERS
//  TICKS_PER_BIT  1  Tx_sample_ENABLE pulses per bit period (1 = tick at baud rate; 16 = 16x ticks)
//  PARITY_EN      1  1: insert parity bit after data; 0: no parity bit
//  PARITY_ODD     0  0: even parity (XOR of data); 1: odd parity (inverted XOR)
// PORTS
//  Clk               in   1  system clock, 50 MHz
//  reset             in   1  synchronous, active-high reset
//  Tx_sample_ENABLE  in   1  1-cycle baud tick from baud_rate_generator
//  Tx_EN             in   1  transmitter enable; gates acceptance of new writes
//  Tx_WR             in   1  write strobe; byte accepted when Tx_EN=1 and Tx_BUSY=0
//  Tx_DATA           in   8  byte to send; sampled in the accepting cycle only
//  Tx_D              out  1  serial line; idle high
//  Tx_BUSY           out  1  frame in progress (incl. wait for first tick)
//  Tx_DONE           out  1  1-cycle pulse when the stop bit completes
// BEHAVIOUR
//  Reset (sync, active-high): next edge forces Tx_D=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, counters=0.
//   Applies mid-frame; the partial frame is abandoned and the line returns high.
//  All outputs are registered.
//  FSM states: IDLE, WAIT_TICK, START, DATA, PARITY, STOP.
//   IDLE: Tx_D=1. Tx_WR & Tx_EN -> latch Tx_DATA into shift reg and compute parity; Tx_BUSY=1
//     from next cycle; go to WAIT_TICK.
//   WAIT_TICK: Tx_D=1; first Tx_sample_ENABLE -> START. Aligns the start edge to the tick phase.
//   START: Tx_D=0 from the cycle after that tick.
//   Bit timing: a tick counter (0..TICKS_PER_BIT-1) increments on each tick. A bit ends on the
//     tick where the counter = TICKS_PER_BIT-1; the counter then clears and the next bit drives
//     Tx_D on the following cycle.
//   DATA: shift out bit0..bit7 (bit index 0..7, wraps to 0 on exit).
//     Exit -> PARITY if PARITY_EN, else STOP.
//   PARITY: Tx_D = ^data ^ PARITY_ODD.
//   STOP: Tx_D=1. On the final tick -> IDLE, with Tx_BUSY=0 and Tx_DONE=1 on the same next cycle.
//  Acceptance: Tx_WR while Tx_BUSY=1 or Tx_EN=0 is ignored; no queueing.
//   Back-to-back: a Tx_WR in the first IDLE cycle (the Tx_DONE cycle) is accepted.
//  Tx_EN falling mid-frame: the current frame completes normally; further writes are refused.
//  Tx_DATA changing after acceptance has no effect on the frame in flight.
//  Tx_sample_ENABLE ignored in IDLE.
//  Frame length: 10 bits (no parity) or 11 bits, each TICKS_PER_BIT ticks long.
//  Latency: write -> start edge = 1 cycle + wait for next tick + 1 cycle.
// STRUCTURE
//  Shared package uart_defs: FSM state encodings; UART_IDLE_LEVEL=1; DATA_W=8; baud_select
//   encodings 3'b000..3'b111 = 300..115200 baud (shared with the receiver and baud_rate_generator).
//  Single flat module; no sub-module. baud_rate_generator is instantiated beside it at the UART
//   top level, not inside.
// TESTING
//  T1: TICKS_PER_BIT=1, tick every 4 Clk; Tx_WR with 0xA5 -> Tx_D = 0,1,0,1,0,0,1,0,1,0(par),1;
//      Tx_DONE after 11 ticks.
//  T2: 0x07, even parity -> parity bit 1; PARITY_ODD=1 -> parity bit 0;
//      PARITY_EN=0 -> 10-bit frame, no parity slot.
//  T3: TICKS_PER_BIT=16 -> each bit held exactly 16 ticks (64 Clk); start edge 1 cycle after a tick.
//  T4: Tx_WR mid-frame with 0xFF -> ignored, frame unchanged; Tx_WR in the Tx_DONE cycle ->
//      accepted, next frame follows.
//  T5: Tx_EN=0 with Tx_WR -> Tx_BUSY stays 0, Tx_D stays 1;
//      Tx_EN dropped mid-frame -> frame completes.
//  T6: reset asserted during DATA bit 3 -> next edge Tx_D=1, Tx_BUSY=0;
//      a new write after release sends a clean frame.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: shared UART constants, FSM encodings and baud select codes
package uart_defs;
    localparam int   DATA_W          = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TICK = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_PARITY    = 3'd4;
    localparam logic [2:0] ST_STOP      = 3'd5;

    typedef enum logic [2:0] {
        BAUD_300    = 3'b000,
        BAUD_1200   = 3'b001,
        BAUD_2400   = 3'b010,
        BAUD_4800   = 3'b011,
        BAUD_9600   = 3'b100,
        BAUD_19200  = 3'b101,
        BAUD_57600  = 3'b110,
        BAUD_115200 = 3'b111
    } baud_sel_e;
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per frame (start, 8 data LSB first, optional parity, stop)
// on baud ticks from the baud rate generator; all outputs registered.
module uart_transmitter
    import uart_defs::*;
#(
    parameter int TICKS_PER_BIT = 1,
    parameter bit PARITY_EN     = 1'b1,
    parameter bit PARITY_ODD    = 1'b0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Tx_sample_ENABLE,
    input  logic              Tx_EN,
    input  logic              Tx_WR,
    input  logic [DATA_W-1:0] Tx_DATA,
    output logic              Tx_D,
    output logic              Tx_BUSY,
    output logic              Tx_DONE
);
    localparam int CW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;

    logic [2:0]        state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [2:0]        bidx_q, bidx_d;
    logic [CW-1:0]     tcnt_q, tcnt_d;
    logic              in_frame, bit_end;

    assign in_frame = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign bit_end  = Tx_sample_ENABLE && tcnt_q == CW'(TICKS_PER_BIT - 1);

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        par_d   = par_q;
        sh_d    = sh_q;
        bidx_d  = bidx_q;
        tcnt_d  = tcnt_q;
        if (in_frame && Tx_sample_ENABLE)
            tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (Tx_WR && Tx_EN) begin
                    sh_d    = Tx_DATA;
                    par_d   = ^Tx_DATA ^ PARITY_ODD;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_TICK;
                end
            end
            // start edge is aligned to the tick phase, not to the write
            ST_WAIT_TICK: if (Tx_sample_ENABLE) begin
                tx_d    = 1'b0;
                tcnt_d  = '0;
                state_d = ST_START;
            end
            ST_START: if (bit_end) begin
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
                bidx_d  = 3'd0;
                state_d = ST_DATA;
            end
            ST_DATA: if (bit_end) begin
                bidx_d = bidx_q + 3'd1;
                if (bidx_q == 3'd7) begin
                    tx_d    = PARITY_EN ? par_q : UART_IDLE_LEVEL;
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end else begin
                    tx_d = sh_q[0];
                    sh_d = sh_q >> 1;
                end
            end
            ST_PARITY: if (bit_end) begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = ST_STOP;
            end
            ST_STOP: if (bit_end) begin
                tx_d    = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
            sh_q    <= '0;
            bidx_q  <= 3'd0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            par_q   <= par_d;
            sh_q    <= sh_d;
            bidx_q  <= bidx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign Tx_D    = tx_q;
    assign Tx_BUSY = busy_q;
    assign Tx_DONE = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frames on four parameter variants, checked bit-by-bit per cycle
// against frames built from the written bytes.
module tb_uart_transmitter;
    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b1;
    logic [7:0] data = 8'h00;
    logic [3:0] wr = 4'h0;
    logic [3:0] txd, busy, done;
    int         tc = 0;
    int         nvec = 0;
    int         nbad = 0;

    typedef struct {
        int          idx;
        logic [10:0] bits;
        int          nb;
    } frame_t;
    frame_t sb[$];

    int tpb[4]  = '{1, 1, 1, 16};
    bit pen[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit podd[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    always #5 Clk = ~Clk;

    initial forever begin
        @(negedge Clk);
        tc = (tc + 1) % 4;
        tick = (tc == 0);
    end

    uart_transmitter #(.TICKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
        .Clk(Clk), .reset(reset), .Tx_sample_ENABLE(tick), .Tx_EN(en), .Tx_WR(wr[0]),
        .Tx_DATA(data), .Tx_D(txd[0]), .Tx_BUSY(busy[0]), .Tx_DONE(done[0]));
    uart_transmitter #(.TICKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
        .Clk(Clk), .reset(reset), .Tx_sample_ENABLE(tick), .Tx_EN(en), .Tx_WR(wr[1]),
        .Tx_DATA(data), .Tx_D(txd[1]), .Tx_BUSY(busy[1]), .Tx_DONE(done[1]));
    uart_transmitter #(.TICKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
        .Clk(Clk), .reset(reset), .Tx_sample_ENABLE(tick), .Tx_EN(en), .Tx_WR(wr[2]),
        .Tx_DATA(data), .Tx_D(txd[2]), .Tx_BUSY(busy[2]), .Tx_DONE(done[2]));
    uart_transmitter #(.TICKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u3 (
        .Clk(Clk), .reset(reset), .Tx_sample_ENABLE(tick), .Tx_EN(en), .Tx_WR(wr[3]),
        .Tx_DATA(data), .Tx_D(txd[3]), .Tx_BUSY(busy[3]), .Tx_DONE(done[3]));

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk(input int idx, input logic [7:0] d);
        frame_t f;
        f.idx = idx;
        f.bits = '1;
        f.bits[0] = 1'b0;
        f.bits[8:1] = d;
        if (pen[idx]) f.bits[9] = ^d ^ podd[idx];
        f.nb = pen[idx] ? 11 : 10;
        return f;
    endfunction

    task automatic wr_byte(input int idx, input logic [7:0] d, input bit acc);
        data = d;
        wr[idx] = 1'b1;
        cyc();
        wr[idx] = 1'b0;
        data = ~d;
        if (acc) sb.push_back(mk(idx, d));
        chk("busy_after_wr", 32'(busy[idx]), 32'(acc));
    endtask

    task automatic idle_chk(input int idx, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            chk("idle_txd", 32'(txd[idx]), 32'd1);
            chk("idle_busy", 32'(busy[idx]), 32'd0);
        end
    endtask

    // act: 1 = write 0xFF mid-frame, 2 = drop Tx_EN, 3 = reset (frame abandoned)
    task automatic rx(input int act, input int act_n);
        frame_t f;
        int idx, p;
        bit hit;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        f = sb.pop_front();
        idx = f.idx;
        p = 4 * tpb[idx];
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc();
            if (txd[idx] === 1'b0) hit = 1'b1;
        end
        chk("start_seen", 32'(hit), 32'd1);
        if (!hit) return;
        chk("start_after_tick", 32'(tick), 32'd1);
        for (int n = 0; n <= f.nb * p; n++) begin
            if (n > 0) cyc();
            wr[idx] = 1'b0;
            if (n < f.nb * p) begin
                chk("bit", 32'(txd[idx]), 32'(f.bits[n / p]));
                chk("busy_frame", 32'(busy[idx]), 32'd1);
                if (n == f.nb * p - 1) chk("done_early", 32'(done[idx]), 32'd0);
            end else begin
                chk("done", 32'(done[idx]), 32'd1);
                chk("busy_end", 32'(busy[idx]), 32'd0);
                chk("stop_idle", 32'(txd[idx]), 32'd1);
            end
            if (n == act_n) begin
                if (act == 1) begin
                    data = 8'hFF;
                    wr[idx] = 1'b1;
                end
                if (act == 2) en = 1'b0;
                if (act == 3) begin
                    reset = 1'b1;
                    cyc();
                    chk("rst_txd", 32'(txd[idx]), 32'd1);
                    chk("rst_busy", 32'(busy[idx]), 32'd0);
                    chk("rst_done", 32'(done[idx]), 32'd0);
                    reset = 1'b0;
                    return;
                end
            end
        end
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset_txd", 32'(txd), 32'hF);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 1'b0;
        cyc();
        // T1 / T2: parity variants
        wr_byte(0, 8'hA5, 1'b1); rx(0, -1);
        wr_byte(0, 8'h07, 1'b1); rx(0, -1);
        wr_byte(1, 8'h07, 1'b1); rx(0, -1);
        wr_byte(2, 8'h07, 1'b1); rx(0, -1);
        wr_byte(2, 8'hC4, 1'b1); rx(0, -1);
        // T3: 16 ticks per bit
        wr_byte(3, 8'hA5, 1'b1); rx(0, -1);
        // T4: mid-frame write ignored, write in DONE cycle accepted
        wr_byte(0, 8'h5A, 1'b1); rx(1, 10);
        wr_byte(0, 8'h3C, 1'b1); rx(0, -1);
        idle_chk(0, 8);
        // T5: Tx_EN gating
        en = 1'b0;
        wr_byte(0, 8'h55, 1'b0); idle_chk(0, 20);
        en = 1'b1;
        wr_byte(0, 8'h81, 1'b1); rx(2, 8);
        wr_byte(0, 8'h99, 1'b0); idle_chk(0, 10);
        en = 1'b1;
        // T6: reset during data bit 3, then a clean frame
        wr_byte(0, 8'hC3, 1'b1); rx(3, 17);
        idle_chk(0, 6);
        wr_byte(0, 8'h96, 1'b1); rx(0, -1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
